// File: rtl/axis_data_width_converter_pkt.sv
// rtl/axis_data_width_converter_pkt.sv - AXI-Stream byte-width converter carrying tkeep/tlast/tuser
module axis_data_width_converter_pkt #(
  parameter int SLAVE_WIDTH  = 16,
  parameter int MASTER_WIDTH = 2,
  parameter int USER_WIDTH   = 1
) (
  input  logic                      aclk,
  input  logic                      arst,
  input  logic [SLAVE_WIDTH*8-1:0]  s_axis_tdata,
  input  logic [SLAVE_WIDTH-1:0]    s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic [USER_WIDTH-1:0]     s_axis_tuser,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [MASTER_WIDTH*8-1:0] m_axis_tdata,
  output logic [MASTER_WIDTH-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [USER_WIDTH-1:0]     m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int MAX_W = (SLAVE_WIDTH > MASTER_WIDTH) ? SLAVE_WIDTH : MASTER_WIDTH;
  localparam int MIN_W = (SLAVE_WIDTH > MASTER_WIDTH) ? MASTER_WIDTH : SLAVE_WIDTH;
  localparam int RATIO = MAX_W / MIN_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (MIN_W < 1 || USER_WIDTH < 1 || (MAX_W % MIN_W) != 0) begin : g_bad_params
      $error("axis_data_width_converter_pkt: widths must be >= 1 and the larger a multiple of the smaller");

    end else if (SLAVE_WIDTH == MASTER_WIDTH) begin : g_pass
      logic [MASTER_WIDTH*8-1:0] r_data;
      logic [MASTER_WIDTH-1:0]   r_keep;
      logic                      r_last;
      logic [USER_WIDTH-1:0]     r_user;
      logic                      r_valid;
      logic                      w_s_ready;

      assign w_s_ready = ~arst & (~r_valid | m_axis_tready);

      // Single skid-free register stage: load on accept, empty on handoff
      always_ff @(posedge aclk) begin
        if (arst) begin
          r_data  <= '0;
          r_keep  <= '0;
          r_last  <= 1'b0;
          r_user  <= '0;
          r_valid <= 1'b0;
        end else if (s_axis_tvalid && w_s_ready) begin
          r_data  <= s_axis_tdata;
          r_keep  <= s_axis_tkeep;
          r_last  <= s_axis_tlast;
          r_user  <= s_axis_tuser;
          r_valid <= 1'b1;
        end else if (m_axis_tready) begin
          r_valid <= 1'b0;
        end
      end

      assign s_axis_tready = w_s_ready;
      assign m_axis_tdata  = r_data;
      assign m_axis_tkeep  = r_keep;
      assign m_axis_tlast  = r_last;
      assign m_axis_tuser  = r_user;
      assign m_axis_tvalid = r_valid;

    end else if (MASTER_WIDTH > SLAVE_WIDTH) begin : g_upsize
      logic [MASTER_WIDTH*8-1:0] r_data;
      logic [MASTER_WIDTH-1:0]   r_keep;
      logic                      r_last;
      logic [USER_WIDTH-1:0]     r_user;
      logic                      r_valid;
      logic [CNT_W-1:0]          r_cnt;
      logic                      w_s_ready;
      logic                      w_s_accept;
      logic                      w_close;

      assign w_s_ready  = ~arst & (~r_valid | m_axis_tready);
      assign w_s_accept = s_axis_tvalid & w_s_ready;
      assign w_close    = s_axis_tlast | (r_cnt == CNT_W'(RATIO - 1));

      // Output register is the accumulator; lane 0 of a new word wipes the stale lanes
      always_ff @(posedge aclk) begin
        if (arst) begin
          r_data  <= '0;
          r_keep  <= '0;
          r_last  <= 1'b0;
          r_user  <= '0;
          r_valid <= 1'b0;
          r_cnt   <= '0;
        end else if (w_s_accept) begin
          for (int i = 0; i < RATIO; i++) begin
            if (r_cnt == CNT_W'(i)) begin
              r_data[i*SLAVE_WIDTH*8 +: SLAVE_WIDTH*8] <= s_axis_tdata;
              r_keep[i*SLAVE_WIDTH +: SLAVE_WIDTH]     <= s_axis_tkeep;
            end else if (r_cnt == '0) begin
              r_data[i*SLAVE_WIDTH*8 +: SLAVE_WIDTH*8] <= '0;
              r_keep[i*SLAVE_WIDTH +: SLAVE_WIDTH]     <= '0;
            end
          end
          if (r_cnt == '0) begin
            r_user <= s_axis_tuser;
          end
          if (w_close) begin
            r_valid <= 1'b1;
            r_last  <= s_axis_tlast;
            r_cnt   <= '0;
          end else begin
            r_valid <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
          end
        end else if (m_axis_tready) begin
          r_valid <= 1'b0;
        end
      end

      assign s_axis_tready = w_s_ready;
      assign m_axis_tdata  = r_data;
      assign m_axis_tkeep  = r_keep;
      assign m_axis_tlast  = r_last;
      assign m_axis_tuser  = r_user;
      assign m_axis_tvalid = r_valid;

    end else begin : g_downsize
      logic [SLAVE_WIDTH*8-1:0] r_hdata;
      logic [SLAVE_WIDTH-1:0]   r_hkeep;
      logic                     r_hlast;
      logic [USER_WIDTH-1:0]    r_huser;
      logic                     r_hvalid;
      logic [CNT_W-1:0]         r_idx;
      logic [CNT_W-1:0]         r_last_idx;
      logic [CNT_W-1:0]         w_top_idx;
      logic [CNT_W-1:0]         w_load_last_idx;
      logic                     w_load_valid;
      logic                     w_on_last;
      logic                     w_s_ready;
      logic                     w_s_accept;

      // Highest chunk of the incoming word that carries any enabled byte
      always_comb begin
        w_top_idx = '0;
        for (int i = 0; i < RATIO; i++) begin
          if (|s_axis_tkeep[i*MASTER_WIDTH +: MASTER_WIDTH]) begin
            w_top_idx = CNT_W'(i);
          end
        end
      end

      // A tlast word stops at its top chunk; an empty non-last word is swallowed
      assign w_load_last_idx = s_axis_tlast ? w_top_idx : CNT_W'(RATIO - 1);
      assign w_load_valid    = s_axis_tlast | (|s_axis_tkeep);
      assign w_on_last       = (r_idx == r_last_idx);
      assign w_s_ready       = ~arst & (~r_hvalid | (m_axis_tready & w_on_last));
      assign w_s_accept      = s_axis_tvalid & w_s_ready;

      // Holding register walks chunk index; reload coincides with the last handoff
      always_ff @(posedge aclk) begin
        if (arst) begin
          r_hdata    <= '0;
          r_hkeep    <= '0;
          r_hlast    <= 1'b0;
          r_huser    <= '0;
          r_hvalid   <= 1'b0;
          r_idx      <= '0;
          r_last_idx <= '0;
        end else if (w_s_accept) begin
          r_hdata    <= s_axis_tdata;
          r_hkeep    <= s_axis_tkeep;
          r_hlast    <= s_axis_tlast;
          r_huser    <= s_axis_tuser;
          r_hvalid   <= w_load_valid;
          r_idx      <= '0;
          r_last_idx <= w_load_last_idx;
        end else if (r_hvalid && m_axis_tready) begin
          if (w_on_last) begin
            r_hvalid <= 1'b0;
            r_idx    <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end

      assign s_axis_tready = w_s_ready;
      assign m_axis_tdata  = r_hdata[r_idx*MASTER_WIDTH*8 +: MASTER_WIDTH*8];
      assign m_axis_tkeep  = r_hkeep[r_idx*MASTER_WIDTH +: MASTER_WIDTH];
      assign m_axis_tlast  = r_hlast & w_on_last;
      assign m_axis_tuser  = r_huser;
      assign m_axis_tvalid = r_hvalid;
    end
  endgenerate

endmodule
